// File: rtl/tdm_demux4_if.sv
// tdm_demux4_if: TDM sample stream in, reassembled lanes and framing status out.
// TDM_DEMUX_ERRCNT_EN adds the err_count signal to the bundle.
interface tdm_demux4_if #(parameter int WIDTH = 1);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_sync;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] c;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic [1:0]       sel;
  logic             locked;
  logic             frame_err;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0]       err_count;
  modport master (output in_data, in_valid, in_sync,
                  input  a, b, c, d, out_valid, sel, locked, frame_err, err_count);
  modport slave  (input  in_data, in_valid, in_sync,
                  output a, b, c, d, out_valid, sel, locked, frame_err, err_count);
`else
  modport master (output in_data, in_valid, in_sync,
                  input  a, b, c, d, out_valid, sel, locked, frame_err);
  modport slave  (input  in_data, in_valid, in_sync,
                  output a, b, c, d, out_valid, sel, locked, frame_err);
`endif
endinterface

// File: rtl/tdm_demux4.sv
// tdm_demux4: reassembles a 4-lane TDM stream (a->b->c->d) into registered lanes with framing checks.
// TDM_DEMUX_ERRCNT_EN adds an 8-bit saturating frame error counter.
module tdm_demux4 #(
  parameter int WIDTH = 1
) (
  input logic         clk,
  input logic         rst,
  tdm_demux4_if.slave bus
);
  localparam logic HUNT    = 1'b0;
  localparam logic COLLECT = 1'b1;
  logic             state_q, state_d;
  logic [1:0]       sel_q, sel_d;
  logic [WIDTH-1:0] sh0_q, sh0_d, sh1_q, sh1_d, sh2_q, sh2_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, c_q, c_d, d_q, d_d;
  logic             out_valid_q, out_valid_d, frame_err_q, frame_err_d;
  logic             step, take0, err, done;
  always_comb begin
    step        = bus.in_valid && state_q == COLLECT;
    take0       = bus.in_valid && bus.in_sync;
    // sync anywhere but lane 0 is premature; no sync at lane 0 means alignment is lost
    err         = step && (bus.in_sync ? sel_q != 2'd0 : sel_q == 2'd0);
    done        = step && !bus.in_sync && sel_q == 2'd3;
    state_d     = take0 ? COLLECT : err ? HUNT : state_q;
    sel_d       = take0 ? 2'd1 : (step && sel_q != 2'd0) ? sel_q + 2'd1 : sel_q;
    sh0_d       = take0 ? bus.in_data : sh0_q;
    sh1_d       = (step && !bus.in_sync && sel_q == 2'd1) ? bus.in_data : sh1_q;
    sh2_d       = (step && !bus.in_sync && sel_q == 2'd2) ? bus.in_data : sh2_q;
    a_d         = done ? sh0_q : a_q;
    b_d         = done ? sh1_q : b_q;
    c_d         = done ? sh2_q : c_q;
    d_d         = done ? bus.in_data : d_q;
    out_valid_d = done;
    frame_err_d = err;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= HUNT;
      sel_q       <= '0;
      sh0_q       <= '0;
      sh1_q       <= '0;
      sh2_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      d_q         <= '0;
      out_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      sh0_q       <= sh0_d;
      sh1_q       <= sh1_d;
      sh2_q       <= sh2_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      d_q         <= d_d;
      out_valid_q <= out_valid_d;
      frame_err_q <= frame_err_d;
    end
  end
  assign bus.a         = a_q;
  assign bus.b         = b_q;
  assign bus.c         = c_q;
  assign bus.d         = d_q;
  assign bus.out_valid = out_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.sel       = sel_q;
  assign bus.locked    = state_q == COLLECT;
`ifdef TDM_DEMUX_ERRCNT_EN
  logic [7:0] err_count_q, err_count_d;
  always_comb err_count_d = (err && err_count_q != 8'hFF) ? err_count_q + 8'd1 : err_count_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err_count_q <= '0;
    else     err_count_q <= err_count_d;
  end
  assign bus.err_count = err_count_q;
`endif
endmodule
